// File: rtl/bias_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bias_unit : per-column bias add with saturation and optional ReLU.
// Double-buffered bias bank, 1-cycle registered output with backpressure.
// Revision  : 1.0
// ---------------------------------------------------------------------------
module bias_unit #(
  parameter int N_COLS = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bias_wr_en,
  input  logic [$clog2(N_COLS)-1:0]     bias_wr_idx,
  input  logic [DATA_W-1:0]             bias_wr_data,
  input  logic                          bias_commit,
  input  logic                          relu_en_in,
  input  logic [N_COLS-1:0]             sys_valid_in,
  input  logic [N_COLS*DATA_W-1:0]      sys_data_in,
  output logic                          in_ready,
  input  logic                          out_ready,
  output logic [N_COLS-1:0]             z_valid_out,
  output logic [N_COLS*DATA_W-1:0]      z_data_out,
  output logic [15:0]                   sat_count,
  input  logic                          sat_clear
);

  localparam int IDX_W = $clog2(N_COLS);
  localparam int CNT_W = $clog2(N_COLS + 1);

  logic [DATA_W-1:0]        r_shadow [N_COLS];
  logic [DATA_W-1:0]        r_active [N_COLS];
  logic [DATA_W-1:0]        w_shadow_nxt [N_COLS];
  logic                     r_relu;
  logic [N_COLS-1:0]        r_valid;
  logic [N_COLS*DATA_W-1:0] r_data;
  logic [15:0]              r_cnt;

  logic [N_COLS*DATA_W-1:0] w_z_nxt;
  logic [N_COLS-1:0]        w_sat_hit;
  logic [CNT_W-1:0]         w_nsat;
  logic [16:0]              w_cnt_sum;
  logic [15:0]              w_cnt_nxt;

  assign in_ready    = out_ready | ~(|r_valid);
  assign z_valid_out = r_valid;
  assign z_data_out  = r_data;
  assign sat_count   = r_cnt;

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [DATA_W:0]   sum;
    logic              sat;
    logic [DATA_W-1:0] clip;
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] din;

    // A same-cycle shadow write must be visible to a same-cycle commit.
    assign w_shadow_nxt[c] = (bias_wr_en && bias_wr_idx == IDX_W'(c)) ? bias_wr_data
                                                                      : r_shadow[c];

    assign din  = sys_data_in[c*DATA_W +: DATA_W];
    assign sum  = {din[DATA_W-1], din} + {r_active[c][DATA_W-1], r_active[c]};
    assign sat  = sum[DATA_W] ^ sum[DATA_W-1];
    assign clip = !sat         ? sum[DATA_W-1:0] :
                  sum[DATA_W]  ? {1'b1, {(DATA_W-1){1'b0}}} :
                                 {1'b0, {(DATA_W-1){1'b1}}};
    assign res  = (r_relu && clip[DATA_W-1]) ? '0 : clip;

    assign w_z_nxt[c*DATA_W +: DATA_W] = sys_valid_in[c] ? res : '0;
    assign w_sat_hit[c]                = sat & sys_valid_in[c];
  end : g_col

  always_comb begin
    w_nsat = '0;
    for (int i = 0; i < N_COLS; i++) begin
      w_nsat = w_nsat + CNT_W'(w_sat_hit[i]);
    end
  end

  assign w_cnt_sum = {1'b0, r_cnt} + 17'(w_nsat);
  assign w_cnt_nxt = w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_COLS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      r_relu <= 1'b0;
    end else begin
      for (int i = 0; i < N_COLS; i++) begin
        r_shadow[i] <= w_shadow_nxt[i];
        if (bias_commit) begin
          r_active[i] <= w_shadow_nxt[i];
        end
      end
      if (bias_commit) begin
        r_relu <= relu_en_in;
      end
    end
  end

  // Output stage: a beat is taken whenever in_ready, including all-invalid beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (in_ready) begin
        r_valid <= sys_valid_in;
        r_data  <= w_z_nxt;
      end
      if (sat_clear) begin
        r_cnt <= '0;
      end else if (in_ready) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

endmodule : bias_unit
`default_nettype wire

// File: tb/tb_bias_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bias_unit : directed + randomized bench for bias_unit against an
// integer-arithmetic reference model. Revision 1.0
// ---------------------------------------------------------------------------
module tb_bias_unit;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bias_wr_en = 1'b0;
  logic [1:0]    bias_wr_idx = '0;
  logic [DW-1:0] bias_wr_data = '0;
  logic          bias_commit = 1'b0;
  logic          relu_en_in = 1'b0;
  logic [N-1:0]  sys_valid_in = '0;
  logic [N*DW-1:0] sys_data_in = '0;
  logic          in_ready;
  logic          out_ready = 1'b1;
  logic [N-1:0]  z_valid_out;
  logic [N*DW-1:0] z_data_out;
  logic [15:0]   sat_count;
  logic          sat_clear = 1'b0;

  bias_unit #(.N_COLS(N), .DATA_W(DW), .FRAC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_idx  (bias_wr_idx),
    .bias_wr_data (bias_wr_data),
    .bias_commit  (bias_commit),
    .relu_en_in   (relu_en_in),
    .sys_valid_in (sys_valid_in),
    .sys_data_in  (sys_data_in),
    .in_ready     (in_ready),
    .out_ready    (out_ready),
    .z_valid_out  (z_valid_out),
    .z_data_out   (z_data_out),
    .sat_count    (sat_count),
    .sat_clear    (sat_clear)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: biases as signed integers.
  int          m_sh [N];
  int          m_act[N];
  bit          m_relu;
  logic [N-1:0]    m_v;
  logic [N*DW-1:0] m_z;
  int          m_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_sh[i]  = 0;
      m_act[i] = 0;
    end
    m_relu = 0;
    m_v    = '0;
    m_z    = '0;
    m_cnt  = 0;
  endtask

  task automatic idle();
    bias_wr_en   = 0;
    bias_commit  = 0;
    relu_en_in   = 0;
    sys_valid_in = '0;
    sys_data_in  = '0;
    out_ready    = 1;
    sat_clear    = 0;
  endtask

  task automatic setcol(input int c, input logic [DW-1:0] v);
    sys_data_in[c*DW +: DW] = v;
  endtask

  // One clock: inputs already set by the caller; model advances alongside the DUT.
  task automatic step(input bit chk = 1'b1);
    bit              acc;
    int              nsat, s, r;
    logic [31:0]     rv;
    logic signed [DW-1:0] d;
    logic [N-1:0]    nv;
    logic [N*DW-1:0] nz;
    int              ncnt;
    @(negedge clk);
    acc = out_ready || (m_v == '0);
    if (chk) check("in_ready", 64'(in_ready), 64'(acc));
    nv = m_v; nz = m_z; ncnt = m_cnt; nsat = 0;
    if (acc) begin
      nv = sys_valid_in;
      for (int c = 0; c < N; c++) begin
        d = sys_data_in[c*DW +: DW];
        s = int'(d) + m_act[c];
        r = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
        if (m_relu && r < 0) r = 0;
        rv = r;
        nz[c*DW +: DW] = sys_valid_in[c] ? rv[DW-1:0] : '0;
        if (sys_valid_in[c] && (s > 32767 || s < -32768)) nsat++;
      end
    end
    if (sat_clear) ncnt = 0;
    else if (acc) ncnt = (m_cnt + nsat > 65535) ? 65535 : m_cnt + nsat;
    if (bias_wr_en && int'(bias_wr_idx) < N) m_sh[bias_wr_idx] = int'($signed(bias_wr_data));
    if (bias_commit) begin
      for (int c = 0; c < N; c++) m_act[c] = m_sh[c];
      m_relu = relu_en_in;
    end
    @(posedge clk);
    #1;
    m_v = nv; m_z = nz; m_cnt = ncnt;
    if (chk) begin
      check("z_valid", 64'(z_valid_out), 64'(m_v));
      check("z_data", 64'(z_data_out), 64'(m_z));
      check("sat_count", 64'(sat_count), 64'(m_cnt));
    end
  endtask

  task automatic commit_bias(input int c, input logic [DW-1:0] b, input bit relu);
    idle();
    bias_wr_en = 1; bias_wr_idx = 2'(c); bias_wr_data = b;
    bias_commit = 1; relu_en_in = relu;
    step();
    idle();
  endtask

  task automatic beat(input int c, input logic [DW-1:0] v);
    idle();
    sys_valid_in[c] = 1'b1;
    setcol(c, v);
    step();
    idle();
  endtask

  logic [N*DW-1:0] held;

  initial begin
    model_reset();
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(z_valid_out), 64'h0);
    check("rst_data", 64'(z_data_out), 64'h0);
    check("rst_cnt", 64'(sat_count), 64'h0);
    @(negedge clk); rst = 0;

    // Basic bias add
    commit_bias(0, 16'h0100, 0);
    beat(0, 16'h0280);
    check("basic_z0", 64'(z_data_out[0 +: DW]), 64'h0380);
    check("basic_v0", 64'(z_valid_out[0]), 64'h1);

    // Saturation, both rails
    commit_bias(0, 16'h0200, 0);
    beat(0, 16'h7F00);
    check("sat_pos_z", 64'(z_data_out[0 +: DW]), 64'h7FFF);
    check("sat_pos_cnt", 64'(sat_count), 64'd1);
    commit_bias(0, 16'hFE00, 0);
    beat(0, 16'h8100);
    check("sat_neg_z", 64'(z_data_out[0 +: DW]), 64'h8000);
    check("sat_neg_cnt", 64'(sat_count), 64'd2);

    // ReLU
    commit_bias(0, 16'hFF00, 1);
    beat(0, 16'h0080);
    check("relu_neg_z", 64'(z_data_out[0 +: DW]), 64'h0000);
    check("relu_neg_v", 64'(z_valid_out[0]), 64'h1);
    beat(0, 16'h0200);
    check("relu_pos_z", 64'(z_data_out[0 +: DW]), 64'h0100);

    // Backpressure: hold for 3 cycles then release
    commit_bias(0, 16'h0000, 0);
    idle(); out_ready = 0; sys_valid_in = 4'hF; sys_data_in = 64'h0001_0002_0003_0004;
    step();
    held = z_data_out;
    for (int k = 0; k < 3; k++) begin
      idle(); out_ready = 0; sys_valid_in = 4'hF; sys_data_in = 64'h1111_2222_3333_4444;
      step();
      check("bp_ready", 64'(in_ready), 64'h0);
      check("bp_hold", 64'(z_data_out), 64'(held));
    end
    idle(); sys_valid_in = 4'hF; sys_data_in = 64'h0005_0006_0007_0008;
    step();
    check("bp_release", 64'(z_data_out), 64'h0005_0006_0007_0008);

    // Shadow write without commit, then commit alongside a beat
    commit_bias(1, 16'h0000, 0);
    idle(); bias_wr_en = 1; bias_wr_idx = 2'd1; bias_wr_data = 16'h0500;
    sys_valid_in[1] = 1; setcol(1, 16'h0100);
    step();
    check("shadow_old", 64'(z_data_out[DW +: DW]), 64'h0100);
    idle(); bias_commit = 1; sys_valid_in[1] = 1; setcol(1, 16'h0100);
    step();
    check("commit_old", 64'(z_data_out[DW +: DW]), 64'h0100);
    beat(1, 16'h0100);
    check("commit_new", 64'(z_data_out[DW +: DW]), 64'h0600);

    // Mid-stream asynchronous reset
    idle(); sys_valid_in = 4'hF; sys_data_in = 64'h7000_7000_7000_7000;
    step();
    check("pre_rst_v", 64'(z_valid_out), 64'hF);
    idle(); sys_valid_in = 4'hF; sys_data_in = 64'h0100_0200_0300_0400;
    @(negedge clk); #2;
    rst = 1; #1;
    check("arst_valid", 64'(z_valid_out), 64'h0);
    check("arst_cnt", 64'(sat_count), 64'h0);
    check("arst_data", 64'(z_data_out), 64'h0);
    model_reset();
    @(negedge clk); rst = 0; #1;
    check("post_rst_ready", 64'(in_ready), 64'h1);
    beat(1, 16'h1234);
    check("post_rst_bias0", 64'(z_data_out[DW +: DW]), 64'h1234);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      sys_valid_in = 4'($urandom);
      sys_data_in  = {$urandom, $urandom};
      out_ready    = ($urandom_range(0, 9) < 7);
      bias_wr_en   = ($urandom_range(0, 9) < 3);
      bias_wr_idx  = 2'($urandom);
      bias_wr_data = 16'($urandom);
      bias_commit  = ($urandom_range(0, 9) == 0);
      relu_en_in   = 1'($urandom);
      sat_clear    = ($urandom_range(0, 19) == 0);
      step();
    end

    // Counter clamp at 0xFFFF
    idle(); sat_clear = 1; step(); idle();
    for (int c = 0; c < N; c++) begin
      bias_wr_en = 1; bias_wr_idx = 2'(c); bias_wr_data = 16'h7FFF;
      bias_commit = (c == N - 1);
      step();
    end
    idle(); sys_valid_in = 4'hF; sys_data_in = {4{16'h7FFF}};
    for (int k = 0; k < 16400; k++) step(1'b0);
    step();
    check("clamp", 64'(sat_count), 64'hFFFF);
    sat_clear = 1;
    step();
    check("clear_prio", 64'(sat_count), 64'h0);
    sat_clear = 0;
    step();
    check("restart", 64'(sat_count), 64'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_bias_unit
`default_nettype wire

// File: doc/bias_unit.md
BIAS_UNIT -- requirements
Module: bias_unit

Interface
REQ-001 SHALL have parameter N_COLS, default 4, number of systolic-array columns served in parallel.
REQ-002 SHALL have parameter DATA_W, default 16, signed two's-complement fixed-point data width.
REQ-003 SHALL have parameter FRAC_W, default 8, fractional bits (informational; the add is format-agnostic).
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port bias_wr_en  input  1  write one shadow bias entry.
REQ-007 SHALL have port bias_wr_idx  input  $clog2(N_COLS)  shadow entry (column) index.
REQ-008 SHALL have port bias_wr_data  input  DATA_W  signed bias value.
REQ-009 SHALL have port bias_commit  input  1  copy the whole shadow bank to the active bank (layer switch).
REQ-010 SHALL have port relu_en_in  input  1  activation mode sampled with bias_commit (0 = bias only, 1 = bias+ReLU).
REQ-011 SHALL have port sys_valid_in  input  N_COLS  per-column valid from the systolic array.
REQ-012 SHALL have port sys_data_in  input  N_COLS*DATA_W  per-column data; column c occupies bits [c*DATA_W +: DATA_W].
REQ-013 SHALL have port in_ready  output  1  unit accepts sys_* this cycle.
REQ-014 SHALL have port out_ready  input  1  downstream accepts z_* this cycle.
REQ-015 SHALL have port z_valid_out  output  N_COLS  per-column output valid.
REQ-016 SHALL have port z_data_out  output  N_COLS*DATA_W  per-column result, same packing as sys_data_in.
REQ-017 SHALL have port sat_count  output  16  count of saturated results since reset or clear.
REQ-018 SHALL have port sat_clear  input  1  synchronous clear of sat_count.

Function
REQ-019 SHALL hold two bias banks (shadow, active) of N_COLS x DATA_W registers plus an active relu mode bit.
REQ-020 SHALL write shadow[bias_wr_idx] = bias_wr_data on a cycle with bias_wr_en=1; bias_wr_idx >= N_COLS SHALL be ignored.
REQ-021 SHALL on bias_commit=1 copy all shadow entries, including a same-cycle shadow write, to active, and latch relu_en_in.
REQ-022 SHALL use the active bank as it was before the edge for data accepted in the commit cycle; new values apply from the next accepted beat.
REQ-023 SHALL drive in_ready = out_ready OR (z_valid_out == 0), combinationally.
REQ-024 SHALL accept a beat when in_ready=1; the accepted beat is then registered, giving 1-cycle latency to z_*.
REQ-025 SHALL per column compute sum = sys_data + active_bias in DATA_W+1 bits and saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-026 SHALL when relu mode=1 replace a negative saturated sum with 0; saturation is detected before ReLU.
REQ-027 SHALL on an accepted beat load z_valid_out = sys_valid_in, and per column z_data_out = result if valid, else 0.
REQ-028 SHALL when in_ready=0 hold z_valid_out and z_data_out stable and ignore sys_*.
REQ-029 SHALL clear z_valid_out to 0 when out_ready=1 and no new beat with any valid bit is accepted.
REQ-030 SHALL increment sat_count by the number of valid columns that saturate in an accepted beat, clamping at 0xFFFF.
REQ-031 SHALL give sat_clear priority over the increment; the count then restarts from 0 on the next cycle.

Reset
REQ-032 SHALL on rst=1 asynchronously clear z_valid_out, z_data_out, sat_count, both bias banks, and the relu mode bit to 0.
REQ-033 SHALL abandon any in-flight beat on reset mid-stream with no output; in_ready SHALL be 1 once rst falls.

Verification
REQ-034 SHALL load bias col0=0x0100 and commit with relu=0, then send col0=0x0280 valid with out_ready=1 -> next cycle z0=0x0380, z_valid_out[0]=1.
REQ-035 SHALL send data 0x7F00 + bias 0x0200 -> z=0x7FFF and sat_count=1; send data 0x8100 + bias 0xFE00 -> z=0x8000 and sat_count=2.
REQ-036 SHALL commit with relu=1 and bias 0xFF00, then send data 0x0080 -> z=0x0000 with valid; send data 0x0200 -> z=0x0100.
REQ-037 SHALL hold out_ready=0 with an output pending -> in_ready=0 and z stable for 3 cycles; raise out_ready -> pending beat taken and the next beat accepted.
REQ-038 SHALL write shadow col1=0x0500 without commit -> outputs still use the old bias; commit in the same cycle as a beat -> that beat uses the old bias and the next beat uses 0x0500.
REQ-039 SHALL assert rst mid-stream with z_valid_out=0xF -> z_valid_out=0 and sat_count=0 immediately, and after release bias 0 applies.
